reg_bank_concat: RTL
====================

REG_BANK_CONCAT -- requirements
Module: reg_bank_concat

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each register (min 1).
REQ-002 Parameter NUM_REGS, default 8, register count (min 2, max 2**NUM_REGS).
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 WrValid  input  1  write request.
REQ-006 WrReady  output  1  bank can accept a write this cycle.
REQ-007 WrAddr  input  NUM_REGS  target register index.
REQ-008 WrData  input  WIDTH  write data.
REQ-009 ClearReq  input  1  start sequential clear of all registers.
REQ-010 Busy  output  1  clear sequence in progress.
REQ-011 ClearDone  output  1  one-cycle pulse when clear completes.
REQ-012 SelLoad  input  1  load SelIn into select register.
REQ-013 SelIn  input  NUM_REGS  new select value.
REQ-014 SelectOut  output  NUM_REGS  registered select for downstream NUM_REGS-to-1 mux.
REQ-015 ConcatanatedOutputs  output  NUM_REGS*WIDTH  register i at bits [i*WIDTH +: WIDTH], register 0 in the LSBs.
REQ-016 ErrFlag  output  1  sticky error indicator.
REQ-017 ErrClr  input  1  clears ErrFlag.

Function
REQ-018 States IDLE and CLEARING; WrReady SHALL be 1 exactly when state is IDLE (registered, no combinational path from inputs).
REQ-019 Write accepted when WrValid && WrReady; register WrAddr takes WrData on that edge; visible on ConcatanatedOutputs the next cycle (latency 1).
REQ-020 Accepted write with WrAddr >= NUM_REGS SHALL modify no register and set ErrFlag.
REQ-021 ClearReq in IDLE SHALL enter CLEARING next cycle with clear index 0; Busy = (state == CLEARING).
REQ-022 In CLEARING, register[index] SHALL be zeroed each cycle, index incrementing by 1; after index NUM_REGS-1 the state returns to IDLE and ClearDone pulses high for exactly the cycle following the last clear.
REQ-023 Full clear SHALL take exactly NUM_REGS cycles in CLEARING; ClearReq asserted during CLEARING is ignored (no restart, no extension).
REQ-024 ClearReq and an accepted write in the same IDLE cycle: write SHALL complete, then the clear sequence SHALL overwrite it.
REQ-025 WrValid during CLEARING SHALL not be accepted; requester holds WrValid until WrReady.
REQ-026 SelLoad with SelIn < NUM_REGS SHALL update SelectOut next cycle; SelIn >= NUM_REGS SHALL leave SelectOut unchanged and set ErrFlag.
REQ-027 SelLoad is honoured in both states.
REQ-028 ErrFlag set and ErrClr in the same cycle: set SHALL win.

Reset
REQ-029 Reset SHALL immediately force: all registers 0, state IDLE, clear index 0, SelectOut 0, ErrFlag 0, ClearDone 0 (hence WrReady 1, Busy 0 after release).
REQ-030 Reset during CLEARING SHALL abort the sequence without a ClearDone pulse.
REQ-031 First write is acceptable on the first rising edge after Reset deasserts.

Configuration
REQ-032 Macro REG_BANK_CONCAT_BYPASS_EN defined: during an accepted in-range write, the WrAddr slot of ConcatanatedOutputs SHALL show WrData combinationally in the same cycle; all other slots unaffected.
REQ-033 Macro undefined: ConcatanatedOutputs SHALL be purely registered (REQ-019 latency 1); no other behaviour differs.

Verification
REQ-034 Reset, write WrAddr=3 WrData=8'hA5 -> next cycle bits [31:24]=8'hA5, all other bits 0, ErrFlag 0.
REQ-035 Fill all 8 registers with 8'h11..8'h88, pulse ClearReq -> Busy high 8 cycles, WrReady low throughout, ClearDone one pulse, bus all zero.
REQ-036 ClearReq and write WrAddr=0 WrData=8'hFF same IDLE cycle -> reg0 reads 8'hFF one cycle, then 0 after clear; held WrValid during CLEARING accepted only on the first IDLE cycle.
REQ-037 Write WrAddr=9, then SelLoad SelIn=12 -> no register change, SelectOut unchanged, ErrFlag 1; ErrClr -> ErrFlag 0; ErrClr with a new error same cycle -> ErrFlag stays 1.
REQ-038 Assert Reset at clear index 4 -> all outputs at reset values, no ClearDone, WrReady 1 after release.
REQ-039 With REG_BANK_CONCAT_BYPASS_EN, write WrAddr=5 WrData=8'h3C -> bits [47:40]=8'h3C in the same cycle; without the macro, only on the next cycle.

Source files
------------

// File: rtl/reg_bank_concat.sv
// Register bank with sequential clear, select register and sticky error flag.
// Define REG_BANK_CONCAT_BYPASS_EN to forward in-range write data to the bus in the write cycle.
module reg_bank_concat #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      WrValid,
    output logic                      WrReady,
    input  logic [NUM_REGS-1:0]       WrAddr,
    input  logic [WIDTH-1:0]          WrData,
    input  logic                      ClearReq,
    output logic                      Busy,
    output logic                      ClearDone,
    input  logic                      SelLoad,
    input  logic [NUM_REGS-1:0]       SelIn,
    output logic [NUM_REGS-1:0]       SelectOut,
    output logic [NUM_REGS*WIDTH-1:0] ConcatanatedOutputs,
    output logic                      ErrFlag,
    input  logic                      ErrClr
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [NUM_REGS-1:0] LIMIT = NUM_REGS'(NUM_REGS);
    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] CLEARING = 1'b1;

    logic [0:0]          state;
    logic [IW-1:0]       clr_idx;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] sel_q;
    logic                err_q;
    logic                done_q;

    logic wr_fire;
    logic wr_in_range;
    logic wr_ok;
    logic sel_ok;
    logic err_set;
    logic clearing;
    logic clr_last;

    assign clearing    = (state == CLEARING);
    assign wr_fire     = WrValid && (state == IDLE);
    assign wr_in_range = (WrAddr < LIMIT);
    assign wr_ok       = wr_fire && wr_in_range;
    assign sel_ok      = (SelIn < LIMIT);
    assign err_set     = (wr_fire && !wr_in_range) || (SelLoad && !sel_ok);
    assign clr_last    = clearing && (clr_idx == LAST);

    // Ready and busy come straight from the state flop, never from inputs.
    assign WrReady   = (state == IDLE);
    assign Busy      = clearing;
    assign ClearDone = done_q;
    assign SelectOut = sel_q;
    assign ErrFlag   = err_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            clr_idx <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= clr_last;
            case (state)
                IDLE: begin
                    if (ClearReq) begin
                        state   <= CLEARING;
                        clr_idx <= '0;
                    end
                end
                CLEARING: begin
                    if (clr_last) begin
                        state   <= IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    // Writes only land in IDLE and clears only in CLEARING, so they never collide.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (WrAddr == NUM_REGS'(i))) begin
                    regs[i] <= WrData;
                end else if (clearing && (clr_idx == IW'(i))) begin
                    regs[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sel_q <= '0;
        end else if (SelLoad && sel_ok) begin
            sel_q <= SelIn;
        end
    end

    // A new error outranks a simultaneous clear request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (ErrClr) begin
            err_q <= 1'b0;
        end
    end

    always_comb begin
        ConcatanatedOutputs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ConcatanatedOutputs[i*WIDTH +: WIDTH] = regs[i];
`ifdef REG_BANK_CONCAT_BYPASS_EN
            if (wr_ok && (WrAddr == NUM_REGS'(i))) begin
                ConcatanatedOutputs[i*WIDTH +: WIDTH] = WrData;
            end
`endif
        end
    end

endmodule
